// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between a parallel source, the serializer and the
// downstream sequence detector.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: a word transfers on a rising edge where data_valid && data_ready.
    // data_valid may drop without a transfer; data_in is ignored unless it transfers.
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             shift_en;
    logic             seq_out;
    logic             seq_valid;
    logic             word_done;
    logic             busy;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output data_in, data_valid, shift_en,
        input  data_ready, seq_out, seq_valid, word_done, busy, bit_cnt
    );

    modport slave (
        input  data_in, data_valid, shift_en,
        output data_ready, seq_out, seq_valid, word_done, busy, bit_cnt
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage with one word of look-ahead buffering, so that
// back-to-back words leave as a gap-free bit stream.
module seq_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_serializer_if.slave      bus,
    output logic                 dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sreg_shifted;

    assign accept   = bus.data_valid && !hold_full_q;
    assign last_bit = (cnt_q == LAST_IDX);

    // Shift toward whichever end feeds seq_out.
    always_comb begin
        sreg_shifted = sreg_q;
        if (MSB_FIRST != 0) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                // Hold is always empty here, so a new word goes straight to sreg.
                if (accept) begin
                    sreg_d  = bus.data_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (bus.shift_en && last_bit) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sreg_d = bus.data_in;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (bus.shift_en) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CW'(1);
                    end
                    if (accept) begin
                        hold_d      = bus.data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    logic out_bit;
    assign out_bit = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

    assign bus.data_ready = !hold_full_q;
    assign bus.seq_out    = (state_q == S_SHIFT) ? out_bit : IDLE_BIT;
    assign bus.seq_valid  = (state_q == S_SHIFT) && bus.shift_en;
    assign bus.word_done  = (state_q == S_SHIFT) && bus.shift_en && last_bit;
    assign bus.busy       = (state_q == S_SHIFT) || hold_full_q;
    assign bus.bit_cnt    = cnt_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: fixed vector table, directed multi-cycle sequences
// and random traffic checked against a bit-queue model of the output stream.
module tb_seq_serializer;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic dbg_m, dbg_l;

  seq_serializer_if #(.WIDTH(W)) bus ();
  seq_serializer_if #(.WIDTH(W)) lbus ();

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state(dbg_m)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(lbus.slave), .dbg_state(dbg_l)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: every accepted word contributes its bits, in send order, to exp_q.
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int         done_cnt;
  logic [7:0] last_act;
  logic [7:0] last_exp;

  function automatic logic [7:0] pk(logic o, logic v, logic d, logic b, logic r, logic [2:0] c);
    return {o, v, d, b, r, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] d, input logic s);
    bus.data_valid = v;
    bus.data_in    = d;
    bus.shift_en   = s;
    #1;
  endtask

  task automatic check_model(input string name);
    int sz;
    logic e_out, e_valid, e_done, e_busy, e_ready;
    logic [2:0] e_cnt;
    sz      = exp_q.size();
    e_busy  = (sz > 0);
    e_ready = (sz <= W);
    e_valid = (sz > 0) && bus.shift_en;
    e_out   = (sz > 0) ? exp_q[0] : 1'b0;
    e_done  = e_valid && ((sz % W) == 1);
    e_cnt   = (sz > 0) ? 3'(W - (((sz - 1) % W) + 1)) : 3'd0;
    last_exp = pk(e_out, e_valid, e_done, e_busy, e_ready, e_cnt);
    last_act = pk(bus.seq_out, bus.seq_valid, bus.word_done, bus.busy, bus.data_ready, bus.bit_cnt);
    chk(name, {24'd0, last_act}, {24'd0, last_exp});
    if (bus.seq_valid) got_q.push_back(bus.seq_out);
    if (bus.word_done) done_cnt++;
  endtask

  task automatic advance();
    logic take;
    logic popit;
    take  = bus.data_valid && (exp_q.size() <= W);
    popit = (exp_q.size() > 0) && bus.shift_en;
    @(posedge clk);
    if (popit) void'(exp_q.pop_front());
    if (take) for (int i = W - 1; i >= 0; i--) exp_q.push_back(bus.data_in[i]);
    #1;
  endtask

  task automatic cyc(input string name, input logic v, input logic [7:0] d, input logic s);
    drive(v, d, s);
    check_model(name);
    advance();
  endtask

  function automatic logic [15:0] got_bits(int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n && i < got_q.size(); i++) r = {r[14:0], got_q[i]};
    return r;
  endfunction

  // ---------------- table ----------------
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] w;
    logic [7:0] lw;
    bus.data_valid  = 1'b0;
    bus.data_in     = '0;
    bus.shift_en    = 1'b0;
    lbus.data_valid = 1'b0;
    lbus.data_in    = '0;
    lbus.shift_en   = 1'b0;
    done_cnt        = 0;

    do_reset();
    drive(1'b0, 8'h00, 1'b0);
    chk("reset_state", {24'd0, pk(bus.seq_out, bus.seq_valid, bus.word_done, bus.busy, bus.data_ready, bus.bit_cnt)},
        {24'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0)});

    // Single word 8'h35, MSB first: 0,0,1,1,0,1,0,1 then idle.
    w = 8'h35;
    tbl[0] = '{v: 1'b1, d: w, s: 1'b1, exp: pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0)};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{v: 1'b0, d: 8'h00, s: 1'b1,
                 exp: pk(w[8 - i], 1'b1, (i == 8), 1'b1, 1'b1, 3'(i - 1))};
    tbl[9] = '{v: 1'b0, d: 8'h00, s: 1'b1, exp: pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0)};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].s);
      check_model("single_model");
      chk($sformatf("single_tbl%0d", i), {24'd0, last_act}, {24'd0, tbl[i].exp});
      advance();
    end

    // Back-to-back A5 then 5A: 16 contiguous bits, two word_done pulses.
    cyc("b2b", 1'b1, 8'hA5, 1'b1);
    got_q.delete();
    done_cnt = 0;
    cyc("b2b", 1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 15; i++) cyc("b2b", 1'b0, 8'h00, 1'b1);
    chk("b2b_count", got_q.size(), 16);
    chk("b2b_bits", {16'd0, got_bits(16)}, 32'h0000A55A);
    chk("b2b_done", done_cnt, 2);
    cyc("b2b_idle", 1'b0, 8'h00, 1'b1);

    // Stall for three cycles at bit_cnt=2 during 8'hF0.
    cyc("stall", 1'b1, 8'hF0, 1'b1);
    got_q.delete();
    cyc("stall", 1'b0, 8'h00, 1'b1);
    cyc("stall", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      check_model("stall_hold");
      chk("stall_frozen", {30'd0, bus.seq_out, bus.seq_valid}, 32'h2);
      chk("stall_cnt", bus.bit_cnt, 2);
      advance();
    end
    for (int i = 0; i < 6; i++) cyc("stall", 1'b0, 8'h00, 1'b1);
    chk("stall_bits", {24'd0, got_bits(8)}, 32'h000000F0);
    chk("stall_len", got_q.size(), 8);
    cyc("stall_idle", 1'b0, 8'h00, 1'b1);

    // New word arriving exactly on the last-bit edge loads sreg directly.
    cyc("direct", 1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 7; i++) cyc("direct", 1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'hCC, 1'b1);
    check_model("direct_last");
    chk("direct_last_cnt", bus.bit_cnt, 7);
    advance();
    drive(1'b0, 8'h00, 1'b1);
    check_model("direct_next");
    chk("direct_gapless", {29'd0, bus.seq_valid, bus.data_ready, bus.seq_out}, 32'h7);
    chk("direct_cnt0", bus.bit_cnt, 0);
    advance();
    for (int i = 0; i < 8; i++) cyc("direct_drain", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset at bit_cnt=4 of 8'hC3 with 8'h99 held.
    cyc("rst_mid", 1'b1, 8'hC3, 1'b1);
    cyc("rst_mid", 1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 3; i++) cyc("rst_mid", 1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check_model("rst_pre");
    chk("rst_pre_cnt", {30'd0, bus.busy, bus.data_ready}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {24'd0, pk(bus.seq_out, bus.seq_valid, bus.word_done, bus.busy, bus.data_ready, bus.bit_cnt)},
        {24'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0)});
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
    for (int i = 0; i < 12; i++) cyc("rst_after", 1'b0, 8'h00, 1'b1);
    chk("rst_no_leak", got_q.size(), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cyc("random", ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20; i++) cyc("rand_drain", 1'b0, 8'h00, 1'b1);

    // LSB-first instance: 8'h35 leaves as 1,0,1,0,1,1,0,0.
    lw = 8'h35;
    lbus.data_valid = 1'b1;
    lbus.data_in    = lw;
    lbus.shift_en   = 1'b1;
    @(posedge clk);
    #1 lbus.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("lsb_bit%0d", i), {29'd0, lbus.seq_out, lbus.seq_valid, lbus.word_done},
          {29'd0, lw[i], 1'b1, (i == 7)});
      chk($sformatf("lsb_cnt%0d", i), lbus.bit_cnt, i);
      @(posedge clk);
      #1;
    end
    #1;
    chk("lsb_idle", {29'd0, lbus.seq_out, lbus.seq_valid, lbus.busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
